// File: rtl/egress_port_sink_if.sv
// Egress stream interface: FIFO head of the egress port sink toward its consumer.
// Handshake: a word transfers on a rising clk edge where valid and ready are both 1;
// while valid=1 and ready=0 the master holds data/sop/eop/src stable, and the
// slave may drive ready independently of valid.
interface egress_port_sink_if #(
    parameter int WIDTH_DATA = 64,
    parameter int WIDTH_SEL  = 2
);
    logic                  valid;
    logic                  ready;
    logic [WIDTH_DATA-1:0] data;
    logic                  sop;
    logic                  eop;
    logic [WIDTH_SEL-1:0]  src;

    modport master (output valid, output data, output sop, output eop, output src, input ready);
    modport slave  (input valid, input data, input sop, input eop, input src, output ready);
endinterface

// File: rtl/egress_port_sink.sv
// Terminal egress stage for one output port: filters the ring stream by destination,
// strips the destination field, delimits frames by the header length field and
// buffers accepted words in a first-word-fall-through FIFO with almost-full backpressure.
module egress_port_sink #(
    parameter int PORT           = 0,
    parameter int FIFO_DEPTH     = 64,
    parameter int AF_MARGIN      = 4,
    parameter int WIDTH_SEL      = 2,
    parameter int WIDTH_DATA     = 64,
    parameter int WIDTH_LENGTH   = 4,
    parameter int CRC32_LENGTH   = 32,
    parameter int WIDTH_PRIORITY = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            valid_in,
    input  logic [WIDTH_SEL-1:0]            nub_in,
    input  logic [WIDTH_SEL+WIDTH_DATA-1:0] data_in,
    output logic                            keep_out,
    egress_port_sink_if.master              m,
    output logic                            frame_done,
    output logic [15:0]                     frame_cnt,
    output logic                            dbg_state,
    output logic [$clog2(FIFO_DEPTH):0]     dbg_count
);
    localparam int WIDTH_PORT = WIDTH_SEL + WIDTH_DATA;
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int EW         = WIDTH_SEL + 2 + WIDTH_DATA;
    localparam int LEN_LO     = CRC32_LENGTH + WIDTH_PRIORITY;
    localparam logic [AW:0]          AF_LEVEL = (AW+1)'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [WIDTH_SEL-1:0] PORT_SEL = WIDTH_SEL'(PORT);

    typedef enum logic {HDR = 1'b0, BODY = 1'b1} state_t;

    state_t                  state, state_nxt;
    logic [WIDTH_LENGTH-1:0] rem;
    logic [WIDTH_LENGTH-1:0] len;
    logic [WIDTH_SEL-1:0]    src_reg;
    logic [WIDTH_SEL-1:0]    dest;
    logic                    accept;
    logic                    rd;
    logic                    frame_end;
    logic [WIDTH_SEL-1:0]    wr_src;
    logic                    wr_sop;
    logic                    wr_eop;

    logic [EW-1:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count;
    logic [EW-1:0]           head;

    assign dest      = data_in[WIDTH_PORT-1 -: WIDTH_SEL];
    assign len       = data_in[LEN_LO+WIDTH_LENGTH-1 : LEN_LO];
    // Threshold decoded straight from the registered count so backpressure never lags.
    assign keep_out  = (count >= AF_LEVEL);
    assign accept    = valid_in & ~keep_out & (dest == PORT_SEL);
    assign m.valid   = (count != '0);
    assign rd        = m.valid & m.ready;
    assign head      = mem[rd_ptr];
    assign dbg_state = state;
    assign dbg_count = count;

    // Head fields are masked while empty so outputs read zero after reset.
    always_comb begin
        m.data = '0;
        m.sop  = 1'b0;
        m.eop  = 1'b0;
        m.src  = '0;
        if (m.valid) begin
            m.data = head[WIDTH_DATA-1:0];
            m.eop  = head[WIDTH_DATA];
            m.sop  = head[WIDTH_DATA+1];
            m.src  = head[EW-1 -: WIDTH_SEL];
        end
    end

    // Framing FSM: next state, tag bits of the word being written, frame completion.
    always_comb begin
        state_nxt = state;
        wr_src    = src_reg;
        wr_sop    = 1'b0;
        wr_eop    = 1'b0;
        frame_end = 1'b0;
        case (state)
            HDR: begin
                if (accept) begin
                    wr_src = nub_in;
                    wr_sop = 1'b1;
                    wr_eop = (len == '0);
                    if (len != '0) state_nxt = BODY;
                    else           frame_end = 1'b1;
                end
            end
            BODY: begin
                if (accept) begin
                    wr_eop = (rem == WIDTH_LENGTH'(1));
                    if (rem == WIDTH_LENGTH'(1)) begin
                        state_nxt = HDR;
                        frame_end = 1'b1;
                    end
                end
            end
            default: state_nxt = HDR;
        endcase
    end

    // Framing registers: state, remaining body words, header source, completion stats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HDR;
            rem        <= '0;
            src_reg    <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            frame_done <= frame_end;
            if (frame_end) frame_cnt <= frame_cnt + 16'd1;
            if (accept) begin
                if (state == HDR) begin
                    rem     <= len;
                    src_reg <= nub_in;
                end else begin
                    rem <= rem - WIDTH_LENGTH'(1);
                end
            end
        end
    end

    // FIFO storage: payload plus frame tags; contents need no reset since count gates them.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= {wr_src, wr_sop, wr_eop, data_in[WIDTH_DATA-1:0]};
    end

    // FIFO pointers and occupancy; a simultaneous write and read leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (rd)     rd_ptr <= rd_ptr + AW'(1);
            case ({accept, rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
